// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: owns the PC, fetches over a single-outstanding
// req/ready/rvalid port and drives the IF/ID register with stall buffering and flush.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        IFWrite,
  input  logic        Branch,
  input  logic        Jump,
  input  logic [31:0] JumpAddr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction_id,
  output logic [31:0] PC_id
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc;
  } ifid_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] fetch_pc;
  logic        buf_valid;
  ifid_t       buf_q;
  ifid_t       ifid;

  logic        redirect;
  logic [31:0] target;
  logic        rsp;
  logic        b2b;
  logic        accept;
  logic        unused_lsb;

  // Redirect is only trusted while ID is not stalled; its operands are stale otherwise.
  assign redirect   = (Branch | Jump) & IFWrite;
  assign target     = {JumpAddr[31:2], 2'b00};
  assign unused_lsb = ^JumpAddr[1:0];

  assign rsp      = (state == WAIT) & imem_rvalid;
  assign b2b      = rsp & IFWrite & ~redirect;
  assign imem_req = ((state == REQ) & ~buf_valid) | b2b;
  assign accept   = imem_req & imem_ready;

  assign imem_addr      = pc_q;
  assign Instruction_id = ifid.insn;
  assign PC_id          = ifid.pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc_q      <= {RESET_PC[31:2], 2'b00};
      fetch_pc  <= '0;
      buf_valid <= 1'b0;
      buf_q     <= '0;
      ifid      <= '{insn: NOP_INSN, pc: 32'h0};
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          // A request accepted alongside a redirect is already on the wrong path.
          if (accept) state <= redirect ? DROP : WAIT;
        end
        WAIT: begin
          if (imem_rvalid)   state <= (b2b & imem_ready) ? WAIT : REQ;
          else if (redirect) state <= DROP;
        end
        DROP: begin
          // The stale response retires the outstanding slot even if another redirect lands.
          if (imem_rvalid) state <= REQ;
        end
        default: state <= IDLE;
      endcase

      if (accept) fetch_pc <= pc_q;

      if (redirect)    pc_q <= target;
      else if (accept) pc_q <= pc_q + 32'd4;

      if (redirect) begin
        buf_valid <= 1'b0;
      end else if (IFWrite) begin
        buf_valid <= 1'b0;
      end else if (rsp) begin
        buf_valid <= 1'b1;
        buf_q     <= '{insn: imem_rdata, pc: fetch_pc};
      end

      if (IFWrite) begin
        if (redirect)       ifid <= '{insn: NOP_INSN, pc: 32'h0};
        else if (buf_valid) ifid <= buf_q;
        else if (rsp)       ifid <= '{insn: imem_rdata, pc: fetch_pc};
        else                ifid <= '{insn: NOP_INSN, pc: 32'h0};
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: memory responder plus a program-order model of
// which (pc, insn) pairs must reach IF/ID, including flushes, stalls and reset.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        IFWrite = 1'b0, Branch = 1'b0, Jump = 1'b0;
  logic [31:0] JumpAddr = '0;
  logic        imem_ready = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr, Instruction_id, PC_id;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RST_PC), .NOP_INSN(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .IFWrite(IFWrite), .Branch(Branch), .Jump(Jump),
    .JumpAddr(JumpAddr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .Instruction_id(Instruction_id), .PC_id(PC_id)
  );

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory image: low bits 01 so no fetched word can ever look like the NOP bubble.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[31:2] ^ 30'h2AAA_AAAA, 2'b01};
  endfunction

  // memory and stimulus state
  bit          out_busy = 0;
  logic [31:0] out_addr = '0;
  int          out_due = 0, cyc = 0;
  int          p_ready = 100, p_ifw = 100, p_redir = 0, lat_max = 1;
  // program-order model
  logic [31:0] exp_pc = RST_PC;
  logic [31:0] prev_insn = NOP, prev_pc = '0;
  int          deliv = 0;
  logic [31:0] acc_log[$];
  logic [31:0] pcid_log[$];

  task automatic cycle();
    bit          rsp, req_s, acc, redir;
    logic [31:0] a_s, tgt;
    @(negedge clk);
    rsp         = out_busy && (cyc >= out_due);
    imem_rvalid = rsp;
    imem_rdata  = rsp ? mem_f(out_addr) : $urandom;
    imem_ready  = ($urandom_range(99) < p_ready);
    IFWrite     = ($urandom_range(99) < p_ifw);
    Branch      = 1'b0;
    Jump        = 1'b0;
    if ($urandom_range(99) < p_redir) begin
      if ($urandom_range(1) == 1) Jump = 1'b1;
      else                        Branch = 1'b1;
    end
    if ($urandom_range(3) == 0) JumpAddr = 32'hFFFF_FFF0 | 32'($urandom_range(15));
    else                        JumpAddr = $urandom & 32'h0000_FFFF;
    #1;
    req_s = imem_req;
    a_s   = imem_addr;
    acc   = req_s && imem_ready;
    redir = IFWrite && (Branch || Jump);
    tgt   = {JumpAddr[31:2], 2'b00};
    if (req_s) chk("addr_align", {30'b0, a_s[1:0]}, 32'h0);
    if (acc) begin
      chk("one_outstanding", {31'b0, out_busy && !rsp}, 32'h0);
      acc_log.push_back(a_s);
    end
    @(posedge clk);
    cyc++;
    if (rsp) out_busy = 0;
    if (acc) begin
      out_busy = 1;
      out_addr = a_s;
      out_due  = cyc + $urandom_range(lat_max - 1);
    end
    #1;
    if (!IFWrite) begin
      chk("hold_insn", Instruction_id, prev_insn);
      chk("hold_pc", PC_id, prev_pc);
    end else if (redir) begin
      chk("flush_insn", Instruction_id, NOP);
      chk("flush_pc", PC_id, 32'h0);
      exp_pc = tgt;
    end else if (Instruction_id !== NOP) begin
      chk("deliv_pc", PC_id, exp_pc);
      chk("deliv_insn", Instruction_id, mem_f(PC_id));
      exp_pc += 32'd4;
      deliv++;
    end else begin
      chk("bubble_pc", PC_id, 32'h0);
    end
    prev_insn = Instruction_id;
    prev_pc   = PC_id;
    pcid_log.push_back(PC_id);
  endtask

  initial begin
    bit found;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_insn", Instruction_id, NOP);
    chk("rst_pc", PC_id, 32'h0);

    // streaming at full rate across the 32-bit wrap
    @(posedge clk); #2 rst_n = 1'b1;
    for (int k = 0; k < 8; k++) cycle();
    chk("stream_accepts", 32'(acc_log.size()), 32'd7);
    for (int i = 0; i < 7 && i < acc_log.size(); i++)
      chk("stream_addr", acc_log[i], RST_PC + 32'(4 * i));
    chk("first_pcid0", pcid_log[0], 32'h0);
    chk("first_pcid1", pcid_log[1], 32'h0);
    for (int i = 0; i < 6 && i < acc_log.size(); i++)
      chk("pcid_lag", pcid_log[i + 2], acc_log[i]);

    // random ready/latency, stalls and redirects
    p_ready = 70; p_ifw = 75; p_redir = 8; lat_max = 3; deliv = 0;
    for (int k = 0; k < 2500; k++) cycle();
    chk("progress", {31'b0, deliv > 150}, 32'h1);

    // reset while a request waits on memory
    p_redir = 0;
    found = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      cycle();
      if (out_busy && out_due > cyc) found = 1;
    end
    chk("found_wait", {31'b0, found}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req", {31'b0, imem_req}, 32'h0);
    chk("mid_rst_addr", imem_addr, RST_PC);
    chk("mid_rst_insn", Instruction_id, NOP);
    chk("mid_rst_pc", PC_id, 32'h0);
    out_busy = 0;
    imem_rvalid = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    exp_pc = RST_PC; prev_insn = NOP; prev_pc = '0; deliv = 0;
    p_redir = 8;
    for (int k = 0; k < 300; k++) cycle();
    chk("post_rst_progress", {31'b0, deliv > 10}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
